// File: rtl/tff_pkg.sv
// Shared constants, FSM state type and binomial-parity tap helper for the cascaded T-flip-flop line code.
// Combinational only; the encoder and decoder both use parity_binom to agree on XOR taps.
package tff_pkg;

  localparam int N_MAX = 4;
  localparam int W_MAX = 32;

  typedef enum logic {WARMUP, RUN} tff_dec_state_t;

  // binom(n,k) is odd exactly when the bits of k are a subset of the bits of n (Lucas).
  function automatic logic parity_binom(input int n, input int k);
    return ((k & ~n) == 0);
  endfunction

endpackage

// File: rtl/tff_chain_diff.sv
// N-th order XOR difference of the sampled line: undoes N cascaded T stages.
// One registered bit out per clk, one cycle after tq; no backpressure.
module tff_chain_diff
  import tff_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tq,
  output logic dec
);

  logic [N-1:0] r_hist;
  logic         r_dec;
  logic         w_diff;

  // r_hist[k-1] holds tq from k cycles ago.
  always_comb begin
    w_diff = tq;
    for (int k = 1; k <= N; k++) begin
      if (parity_binom(N, k)) w_diff = w_diff ^ r_hist[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
      r_dec  <= 1'b0;
    end else begin
      r_hist[0] <= tq;
      for (int k = 1; k < N; k++) r_hist[k] <= r_hist[k-1];
      r_dec <= w_diff;
    end
  end

  assign dec = r_dec;

endmodule

// File: rtl/tff_chain_decoder.sv
// Decodes the T-chain line code and packs bits LSB-first into W-bit words on a valid/ready port.
// Encoder data of cycle c is decoded in cycle c+N+1; a word completing while the port is full is dropped (sticky overflow).
module tff_chain_decoder
  import tff_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tq,
  input  logic         align,
  input  logic         clr_ovf,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow
);

  localparam int              WCW       = $clog2(N_MAX + 1);
  localparam int              BCW       = $clog2(W_MAX);
  localparam logic [WCW-1:0]  WARM_LAST = WCW'(N);
  localparam logic [BCW-1:0]  BIT_LAST  = BCW'(W - 1);

  tff_dec_state_t r_state, w_state_nxt;
  logic [WCW-1:0] r_warm;
  logic [BCW-1:0] r_bitcnt;
  logic [W-1:0]   r_shreg;
  logic [W-1:0]   w_word;
  logic [W-1:0]   r_out_data;
  logic           r_out_valid;
  logic           r_overflow;
  logic           w_dec;
  logic           w_run;
  logic           w_complete;
  logic           w_accept;
  logic           w_room;

  tff_chain_diff #(.N(N)) u_diff (
    .clk (clk),
    .rst (rst),
    .tq  (tq),
    .dec (w_dec)
  );

  // The decode pipeline holds stale bits for the first N+1 cycles after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= WARMUP;
      r_warm  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == WARMUP) r_warm <= r_warm + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == WARMUP && r_warm == WARM_LAST) w_state_nxt = RUN;
  end

  assign w_run      = (r_state == RUN);
  assign w_complete = w_run && (r_bitcnt == BIT_LAST);
  assign w_accept   = r_out_valid && out_ready;
  assign w_room     = !r_out_valid || out_ready;

  always_comb begin
    w_word = r_shreg;
    for (int i = 0; i < W; i++) begin
      if (r_bitcnt == BCW'(i)) w_word[i] = w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else if (w_run) begin
      if (w_complete || align) begin
        r_bitcnt <= '0;
        r_shreg  <= '0;
      end else begin
        r_bitcnt <= r_bitcnt + 1'b1;
        r_shreg  <= w_word;
      end
    end
  end

  // Completion into a free (or simultaneously drained) slot wins over plain acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_complete && w_room) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
      if (w_complete && !w_room) r_overflow <= 1'b1;
      else if (clr_ovf)          r_overflow <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_tff_chain_decoder.sv
// Drives four decoders (N=1..4, W=8) from reference T-chain encoders sharing one data stream,
// checking every cycle against a word-level model of the recovered bit stream.
module tb_tff_chain_decoder;

  logic clk = 1'b0;
  logic rst, d, align, clr_ovf, out_ready;
  logic [4:1] enc [1:4];
  logic [7:0] odat [1:4];
  logic       ovld [1:4];
  logic       oovf [1:4];

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;

  bit         data_arr [0:1023];
  int         m_cnt  [1:4];
  logic [7:0] m_part [1:4];
  logic [7:0] m_dat  [1:4];
  bit         m_vld  [1:4];
  bit         m_ovf  [1:4];

  always #5 clk = ~clk;

  // Reference encoder: s1 <= s1^data; sk <= sk^s(k-1); line = sN.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 1; n <= 4; n++) enc[n] <= '0;
    end else begin
      for (int n = 1; n <= 4; n++) begin
        enc[n][1] <= enc[n][1] ^ d;
        for (int k = 2; k <= 4; k++) if (k <= n) enc[n][k] <= enc[n][k] ^ enc[n][k-1];
      end
    end
  end

  for (genvar g = 1; g <= 4; g++) begin : g_dut
    tff_chain_decoder #(.N(g), .W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tq        (enc[g][g]),
      .align     (align),
      .clr_ovf   (clr_ovf),
      .out_data  (odat[g]),
      .out_valid (ovld[g]),
      .out_ready (out_ready),
      .overflow  (oovf[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Bit decoded in cycle t is the encoder data of cycle t-n-1; shifting starts at t=n+1.
  task automatic model_step(input int n);
    logic       b;
    logic [7:0] word;
    bit         run;
    bit         set;
    run = (t >= n + 1);
    b   = run ? data_arr[t-n-1] : 1'b0;
    set = 0;
    if (run && m_cnt[n] == 7) begin
      word    = m_part[n];
      word[7] = b;
      if (!m_vld[n] || out_ready) begin
        m_dat[n] = word;
        m_vld[n] = 1;
      end else begin
        m_ovf[n] = 1;
        set      = 1;
      end
      m_cnt[n]  = 0;
      m_part[n] = '0;
    end else begin
      if (m_vld[n] && out_ready) m_vld[n] = 0;
      if (run) begin
        if (align) begin
          m_cnt[n]  = 0;
          m_part[n] = '0;
        end else begin
          m_part[n][m_cnt[n]] = b;
          m_cnt[n]++;
        end
      end
    end
    if (!set && clr_ovf) m_ovf[n] = 0;
  endtask

  // Inputs for cycle t are already applied; advance one clock and compare all DUTs.
  task automatic tick();
    data_arr[t] = d;
    for (int n = 1; n <= 4; n++) model_step(n);
    @(negedge clk);
    t++;
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("n%0d_valid", n), 32'(ovld[n]), 32'(m_vld[n]));
      chk($sformatf("n%0d_data", n),  32'(odat[n]), 32'(m_dat[n]));
      chk($sformatf("n%0d_ovf", n),   32'(oovf[n]), 32'(m_ovf[n]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int n = 1; n <= 4; n++) begin
      chk($sformatf("n%0d_rst_valid", n), 32'(ovld[n]), 32'h0);
      chk($sformatf("n%0d_rst_data", n),  32'(odat[n]), 32'h0);
      chk($sformatf("n%0d_rst_ovf", n),   32'(oovf[n]), 32'h0);
      m_cnt[n] = 0; m_part[n] = '0; m_dat[n] = '0; m_vld[n] = 0; m_ovf[n] = 0;
    end
    d = 0; align = 0; clr_ovf = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    t   = 0;
  endtask

  initial begin
    logic [31:0] pat;
    logic [7:0]  got [$];
    int          tw  [$];
    int          pr;
    rst = 1'b1; d = 0; align = 0; clr_ovf = 0; out_ready = 0;
    #2;

    // 0xA5 from cycle 0 appears at cycle N+9 for every N
    do_reset();
    out_ready = 1;
    pat = 32'hA5;
    for (int c = 0; c < 16; c++) begin
      d = pat[c];
      tick();
      for (int n = 1; n <= 4; n++) begin
        if (t == n + 9) begin
          chk($sformatf("a5_n%0d_valid", n), 32'(ovld[n]), 32'h1);
          chk($sformatf("a5_n%0d_data", n),  32'(odat[n]), 32'hA5);
        end else if (t == n + 8) begin
          chk($sformatf("a5_n%0d_early", n), 32'(ovld[n]), 32'h0);
        end
      end
    end

    // back-to-back stream 00,FF,3C,81
    do_reset();
    out_ready = 1;
    pat = 32'h813CFF00;
    for (int c = 0; c < 48; c++) begin
      d = pat[c];
      tick();
      if (ovld[2]) begin
        got.push_back(odat[2]);
        tw.push_back(t);
      end
    end
    chk("stream_count", 32'(got.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        chk($sformatf("stream_w%0d", i),   32'(got[i]), (pat >> (8 * i)) & 32'hFF);
        chk($sformatf("stream_t%0d", i),   32'(tw[i]),  32'(11 + 8 * i));
      end
    end
    chk("stream_ovf", 32'(oovf[2]), 32'h0);

    // stalled consumer: hold word 1, overflow at word 2, then clear and drain
    do_reset();
    out_ready = 0;
    pat = $urandom & 32'hFFFFFF;
    for (int c = 0; c < 28; c++) begin
      d = (c < 24) ? pat[c] : 1'b0;
      tick();
      if (t >= 11) begin
        chk("hold_valid", 32'(ovld[2]), 32'h1);
        chk("hold_data",  32'(odat[2]), pat & 32'hFF);
      end
      if (t == 18) chk("ovf_before", 32'(oovf[2]), 32'h0);
      if (t == 19) chk("ovf_set",    32'(oovf[2]), 32'h1);
    end
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("ovf_clr", 32'(oovf[2]), 32'h0);
    chk("drain_data", 32'(odat[2]), pat & 32'hFF);
    out_ready = 1;
    tick();
    chk("drain_valid", 32'(ovld[2]), 32'h0);

    // align while bitcnt=5 (cycle 8 for N=2): next word is data bits 6..13
    do_reset();
    out_ready = 1;
    pat = 32'hB72D;
    for (int c = 0; c < 24; c++) begin
      d     = pat[c];
      align = (c == 8);
      tick();
      if (t == 11) chk("align_no_word", 32'(ovld[2]), 32'h0);
      if (t == 17) begin
        chk("align_valid", 32'(ovld[2]), 32'h1);
        chk("align_data",  32'(odat[2]), (pat >> 6) & 32'hFF);
      end
    end
    align = 0;

    // reset mid-word with a held word, then 0x5A from the new cycle 0
    do_reset();
    out_ready = 0;
    for (int c = 0; c < 14; c++) begin
      d = 1'($urandom);
      tick();
    end
    chk("pre_rst_valid", 32'(ovld[2]), 32'h1);
    do_reset();
    out_ready = 1;
    pat = 32'h5A;
    for (int c = 0; c < 16; c++) begin
      d = pat[c];
      tick();
      for (int n = 1; n <= 4; n++) begin
        if (t == n + 9) chk($sformatf("5a_n%0d_data", n), 32'(odat[n]), 32'h5A);
      end
    end

    // random traffic with varying consumer stall density
    for (int r = 0; r < 3; r++) begin
      do_reset();
      pr = (r == 0) ? 7 : (r == 1) ? 4 : 1;
      for (int c = 0; c < 500; c++) begin
        d         = 1'($urandom);
        align     = ($urandom_range(15) == 0);
        clr_ovf   = ($urandom_range(15) == 0);
        out_ready = ($urandom_range(7) < pr);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
